// File: rtl/mips_trace_buffer.sv
// Write-event trace recorder for the multicycle MIPS core, drained over a valid/ready port.
// Optional feature: define TRACE_TIMESTAMP_EN to stamp each entry with a 16-bit cycle count.
module mips_trace_buffer #(
   parameter int DEPTH   = 16,
   parameter int ADDR_W  = 4,
   parameter int ENTRY_W =
`ifdef TRACE_TIMESTAMP_EN
      114
`else
      98
`endif
) (
   input  logic               Clk,
   input  logic               reset,
   input  logic               arm,
   input  logic               disarm,
   input  logic               trig_en,
   input  logic [31:0]        trig_pc,
   input  logic               wrap_mode,
   input  logic [31:0]        PC,
   input  logic               RegWrite,
   input  logic [4:0]         WriteRegister,
   input  logic [31:0]        WriteDataReg,
   input  logic               wr,
   input  logic [31:0]        Address,
   input  logic [31:0]        WriteDataMem,
   output logic               rd_valid,
   input  logic               rd_ready,
   output logic [ENTRY_W-1:0] rd_data,
   output logic [ADDR_W:0]    count,
   output logic               full,
   output logic [1:0]         state,
   output logic [7:0]         drop_cnt
);

   typedef enum logic [1:0] {
      IDLE    = 2'b00,
      ARMED   = 2'b01,
      CAPTURE = 2'b10,
      FROZEN  = 2'b11
   } state_t;

   localparam logic [ADDR_W:0] FULL_CNT = (ADDR_W+1)'(DEPTH);
   localparam logic [ADDR_W:0] ONE_CNT  = (ADDR_W+1)'(1);

   state_t              state_q;
   logic [ENTRY_W-1:0]  mem [DEPTH];
   logic [ADDR_W-1:0]   wr_ptr;
   logic [ADDR_W-1:0]   rd_ptr;

   logic                trig_hit;
   logic                capture_win;
   logic                any_ev;
   logic                is_full;
   logic                do_pop;
   logic                do_push;
   logic                do_over;
   logic                arm_go;
   logic [1:0]          drop_inc;
   logic [8:0]          drop_sum;
   logic [ADDR_W:0]     count_next;
   logic [1:0]          ev_kind;
   logic [31:0]         ev_addr;
   logic [31:0]         ev_data;
   logic [ENTRY_W-1:0]  entry_new;

`ifdef TRACE_TIMESTAMP_EN
   logic [15:0]         ts;
`endif

   assign state    = state_q;
   assign rd_valid = (count != '0);
   assign full     = is_full;
   assign rd_data  = mem[rd_ptr];

   // A full FIFO accepts a push only if the head leaves in the same cycle; otherwise the
   // event either overwrites the oldest entry (wrap) or is lost.
   always_comb begin
      trig_hit    = (state_q == ARMED) && (PC == trig_pc);
      capture_win = !disarm && ((state_q == CAPTURE) || trig_hit);
      any_ev      = wr | RegWrite;
      is_full     = (count == FULL_CNT);
      do_pop      = rd_valid && rd_ready;
      do_push     = capture_win && any_ev && (!is_full || do_pop);
      do_over     = capture_win && any_ev && is_full && !do_pop && wrap_mode;
      arm_go      = arm && !disarm && ((state_q == IDLE) || (state_q == FROZEN));

      drop_inc = 2'd0;
      if (capture_win) begin
         drop_inc = {1'b0, wr & RegWrite} + {1'b0, any_ev && is_full && !do_pop};
      end else if ((state_q == FROZEN) && !disarm) begin
         drop_inc = {1'b0, wr} + {1'b0, RegWrite};
      end
      drop_sum = {1'b0, drop_cnt} + {7'b0, drop_inc};

      count_next = count;
      if (do_push && !do_pop) begin
         count_next = count + ONE_CNT;
      end else if (!do_push && do_pop) begin
         count_next = count - ONE_CNT;
      end

      if (wr) begin
         ev_kind = 2'b10;
         ev_addr = Address;
         ev_data = WriteDataMem;
      end else begin
         ev_kind = 2'b01;
         ev_addr = {27'b0, WriteRegister};
         ev_data = WriteDataReg;
      end

`ifdef TRACE_TIMESTAMP_EN
      entry_new = {ts, ev_kind, PC, ev_addr, ev_data};
`else
      entry_new = {ev_kind, PC, ev_addr, ev_data};
`endif
   end

   always_ff @(posedge Clk) begin
      if (reset && (do_push || do_over)) begin
         mem[wr_ptr] <= entry_new;
      end
   end

   // Control FSM plus pointer/occupancy bookkeeping; an accepted arm flushes everything.
   always_ff @(posedge Clk) begin
      if (!reset) begin
         state_q  <= IDLE;
         wr_ptr   <= '0;
         rd_ptr   <= '0;
         count    <= '0;
         drop_cnt <= 8'd0;
`ifdef TRACE_TIMESTAMP_EN
         ts       <= 16'd0;
`endif
      end else if (arm_go) begin
         state_q  <= trig_en ? ARMED : CAPTURE;
         wr_ptr   <= '0;
         rd_ptr   <= '0;
         count    <= '0;
         drop_cnt <= 8'd0;
`ifdef TRACE_TIMESTAMP_EN
         ts       <= 16'd0;
`endif
      end else begin
`ifdef TRACE_TIMESTAMP_EN
         ts <= ts + 16'd1;
`endif
         if (do_push || do_over) begin
            wr_ptr <= wr_ptr + 1'b1;
         end
         if (do_pop || do_over) begin
            rd_ptr <= rd_ptr + 1'b1;
         end
         count    <= count_next;
         drop_cnt <= drop_sum[8] ? 8'hFF : drop_sum[7:0];

         if (disarm) begin
            state_q <= IDLE;
         end else if (capture_win && !wrap_mode && (count_next == FULL_CNT)) begin
            state_q <= FROZEN;
         end else if (trig_hit) begin
            state_q <= CAPTURE;
         end
      end
   end

endmodule

// File: tb/tb_mips_trace_buffer.sv
// Directed self-checking bench for mips_trace_buffer; expected values are hand-derived.
// Also covers the timestamp field when built with TRACE_TIMESTAMP_EN.
module tb_mips_trace_buffer;

   localparam int ENTRY_W =
`ifdef TRACE_TIMESTAMP_EN
      114;
`else
      98;
`endif

   logic               Clk = 1'b0;
   logic               reset;
   logic               arm, disarm, trig_en, wrap_mode;
   logic [31:0]        trig_pc;
   logic [31:0]        PC;
   logic               RegWrite;
   logic [4:0]         WriteRegister;
   logic [31:0]        WriteDataReg;
   logic               wr;
   logic [31:0]        Address;
   logic [31:0]        WriteDataMem;
   logic               rd_valid;
   logic               rd_ready;
   logic [ENTRY_W-1:0] rd_data;
   logic [4:0]         count;
   logic               full;
   logic [1:0]         state;
   logic [7:0]         drop_cnt;

   int total_checks = 0;
   int bad_checks   = 0;

   always #5 Clk = ~Clk;

   mips_trace_buffer dut (
      .Clk(Clk), .reset(reset), .arm(arm), .disarm(disarm), .trig_en(trig_en),
      .trig_pc(trig_pc), .wrap_mode(wrap_mode), .PC(PC), .RegWrite(RegWrite),
      .WriteRegister(WriteRegister), .WriteDataReg(WriteDataReg), .wr(wr),
      .Address(Address), .WriteDataMem(WriteDataMem), .rd_valid(rd_valid),
      .rd_ready(rd_ready), .rd_data(rd_data), .count(count), .full(full),
      .state(state), .drop_cnt(drop_cnt)
   );

   task automatic checkOutput(input string tag, input logic [127:0] actual,
                              input logic [127:0] expected);
      total_checks++;
      if (actual !== expected) begin
         bad_checks++;
         $display("[TB] FAIL %s: got %0h expected %0h", tag, actual, expected);
      end
   endtask

   task automatic tick();
      @(posedge Clk);
      #1;
   endtask

   // Drive one core write cycle, then return the write enables low.
   task automatic applyStimulus(input logic [31:0] pc, input logic rw, input logic [4:0] wreg,
                                input logic [31:0] wdr, input logic w, input logic [31:0] a,
                                input logic [31:0] wdm);
      PC            = pc;
      RegWrite      = rw;
      WriteRegister = wreg;
      WriteDataReg  = wdr;
      wr            = w;
      Address       = a;
      WriteDataMem  = wdm;
      tick();
      RegWrite = 1'b0;
      wr       = 1'b0;
   endtask

   task automatic pulseArm();
      arm = 1'b1;
      tick();
      arm = 1'b0;
   endtask

   task automatic pulseDisarm();
      disarm = 1'b1;
      tick();
      disarm = 1'b0;
   endtask

   initial begin
      logic [15:0] ts_first;
      logic [15:0] ts_delta;

      reset = 1'b0; arm = 1'b0; disarm = 1'b0; trig_en = 1'b0; wrap_mode = 1'b0;
      trig_pc = 32'h0; PC = 32'h0; RegWrite = 1'b0; WriteRegister = 5'd0;
      WriteDataReg = 32'h0; wr = 1'b0; Address = 32'h0; WriteDataMem = 32'h0;
      rd_ready = 1'b0;

      tick();
      tick();
      checkOutput("rst_state", state, 2'b00);
      checkOutput("rst_count", count, 5'd0);
      checkOutput("rst_valid", rd_valid, 1'b0);
      checkOutput("rst_drop", drop_cnt, 8'd0);
      checkOutput("rst_full", full, 1'b0);
      reset = 1'b1;
      tick();

      // Immediate capture of one register write
      pulseArm();
      checkOutput("arm_now_state", state, 2'b10);
      applyStimulus(32'h40, 1'b1, 5'd8, 32'h1234, 1'b0, 32'h0, 32'h0);
      checkOutput("reg_valid", rd_valid, 1'b1);
      checkOutput("reg_entry", rd_data[97:0], {2'b01, 32'h40, 32'h8, 32'h1234});
      rd_ready = 1'b1;
      tick();
      rd_ready = 1'b0;
      checkOutput("pop_count", count, 5'd0);
      checkOutput("pop_valid", rd_valid, 1'b0);

      // PC trigger: the cycle before the trigger PC is ignored, the trigger cycle is kept
      pulseDisarm();
      checkOutput("disarm_state", state, 2'b00);
      trig_en = 1'b1;
      trig_pc = 32'h100;
      pulseArm();
      checkOutput("armed_state", state, 2'b01);
      applyStimulus(32'hFC, 1'b0, 5'd0, 32'h0, 1'b1, 32'h500, 32'h11);
      checkOutput("pretrig_count", count, 5'd0);
      applyStimulus(32'h100, 1'b0, 5'd0, 32'h0, 1'b1, 32'h504, 32'h22);
      checkOutput("trig_count", count, 5'd1);
      checkOutput("trig_state", state, 2'b10);
      checkOutput("trig_entry", rd_data[97:0], {2'b10, 32'h100, 32'h504, 32'h22});

      // Stop-when-full: the 17th event is lost and FROZEN survives a pop
      pulseDisarm();
      trig_en = 1'b0;
      wrap_mode = 1'b0;
      pulseArm();
      checkOutput("flush_count", count, 5'd0);
      for (int i = 1; i <= 17; i++) begin
         applyStimulus(32'h200, 1'b1, 5'd9, 32'(i), 1'b0, 32'h0, 32'h0);
      end
      checkOutput("stop_count", count, 5'd16);
      checkOutput("stop_full", full, 1'b1);
      checkOutput("stop_state", state, 2'b11);
      checkOutput("stop_drop", drop_cnt, 8'd1);
      checkOutput("stop_head", rd_data[31:0], 32'd1);
      rd_ready = 1'b1;
      tick();
      rd_ready = 1'b0;
      checkOutput("frozen_pop_count", count, 5'd15);
      checkOutput("frozen_pop_state", state, 2'b11);
      checkOutput("frozen_pop_head", rd_data[31:0], 32'd2);

      // Overwrite mode, re-armed straight from FROZEN
      wrap_mode = 1'b1;
      pulseArm();
      checkOutput("rearm_state", state, 2'b10);
      checkOutput("rearm_drop", drop_cnt, 8'd0);
      checkOutput("rearm_count", count, 5'd0);
      for (int i = 1; i <= 20; i++) begin
         applyStimulus(32'h300, 1'b1, 5'd10, 32'(i), 1'b0, 32'h0, 32'h0);
      end
      checkOutput("wrap_count", count, 5'd16);
      checkOutput("wrap_drop", drop_cnt, 8'd4);
      checkOutput("wrap_state", state, 2'b10);
      checkOutput("wrap_head", rd_data[31:0], 32'd5);
      // Full with a simultaneous pop: plain push and pop, nothing lost
      rd_ready = 1'b1;
      applyStimulus(32'h300, 1'b1, 5'd10, 32'd21, 1'b0, 32'h0, 32'h0);
      rd_ready = 1'b0;
      checkOutput("wrap_pp_count", count, 5'd16);
      checkOutput("wrap_pp_drop", drop_cnt, 8'd4);
      for (int i = 0; i < 16; i++) begin
         checkOutput("wrap_drain", rd_data[31:0], 32'(6 + i));
         rd_ready = 1'b1;
         tick();
      end
      rd_ready = 1'b0;
      checkOutput("drain_count", count, 5'd0);

      // Simultaneous mem and reg write: mem kept, reg dropped
      pulseDisarm();
      wrap_mode = 1'b0;
      pulseArm();
      applyStimulus(32'h400, 1'b1, 5'd3, 32'h77, 1'b1, 32'h300, 32'hBEEF);
      checkOutput("both_count", count, 5'd1);
      checkOutput("both_drop", drop_cnt, 8'd1);
      checkOutput("both_entry", rd_data[97:0], {2'b10, 32'h400, 32'h300, 32'hBEEF});
      arm = 1'b1;
      disarm = 1'b1;
      tick();
      arm = 1'b0;
      disarm = 1'b0;
      checkOutput("arm_disarm_state", state, 2'b00);
      checkOutput("arm_disarm_count", count, 5'd1);
      rd_ready = 1'b1;
      tick();
      rd_ready = 1'b0;
      checkOutput("idle_pop_count", count, 5'd0);

`ifdef TRACE_TIMESTAMP_EN
      pulseArm();
      applyStimulus(32'h500, 1'b1, 5'd1, 32'h1, 1'b0, 32'h0, 32'h0);
      tick();
      tick();
      applyStimulus(32'h50C, 1'b1, 5'd2, 32'h2, 1'b0, 32'h0, 32'h0);
      ts_first = rd_data[113:98];
      rd_ready = 1'b1;
      tick();
      rd_ready = 1'b0;
      ts_delta = rd_data[113:98] - ts_first;
      checkOutput("ts_delta", ts_delta, 16'd3);
      pulseDisarm();
`else
      ts_first = 16'd0;
      ts_delta = 16'd0;
`endif

      // Reset during capture outranks a concurrent arm
      pulseArm();
      applyStimulus(32'h600, 1'b1, 5'd4, 32'h44, 1'b0, 32'h0, 32'h0);
      reset = 1'b0;
      arm = 1'b1;
      tick();
      reset = 1'b1;
      arm = 1'b0;
      checkOutput("midrst_state", state, 2'b00);
      checkOutput("midrst_count", count, 5'd0);
      checkOutput("midrst_valid", rd_valid, 1'b0);

      $display("test done: total=%0d bad=%0d", total_checks, bad_checks);
      $finish;
   end

   initial begin
      #200000;
      $display("[TB] FAIL timeout: got running expected finished");
      $fatal(1, "[TB] simulation time limit reached");
   end

endmodule
